iter_divider: RTL and testbench

// Multi-cycle radix-2 restoring unsigned divider; the responder side of the divisor/dividend/dout

---
 rtl/iter_divider.sv | 120 ++++++++++++
 tb/tb_iter_divider.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring unsigned divider.
// Accepts one {dividend, divisor} pair when idle and returns {quotient, remainder}
// WIDTH+1 clock edges later as a one-cycle Dout_valid pulse.
// Ports:
//   Clk, Rst_n                      clock, asynchronous active-low reset
//   Divisor_valid/Divisor_data      divisor operand
//   Dividend_valid/Dividend_data    dividend operand (accepted only together with divisor)
//   Ready                           high while idle; operands accepted this cycle
//   Dout_valid                      one-cycle pulse marking a new result
//   Dout_data                       {quotient, remainder}, held until the next result
//   Div_zero                        operation was started with a zero divisor
module iter_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Divisor_valid,
    input  logic [WIDTH-1:0]     Divisor_data,
    input  logic                 Dividend_valid,
    input  logic [WIDTH-1:0]     Dividend_data,
    output logic                 Ready,
    output logic                 Dout_valid,
    output logic [2*WIDTH-1:0]   Dout_data,
    output logic                 Div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvsr;
    logic [CNT_W-1:0]   cnt;

    logic               accept_c;
    logic               last_c;
    logic [WIDTH:0]     shifted_c;
    logic [WIDTH:0]     diff_c;
    logic               borrow_c;
    logic [WIDTH-1:0]   rem_step_c;
    logic [WIDTH-1:0]   quo_step_c;

    assign Ready    = (state == IDLE);
    assign accept_c = (state == IDLE) && Divisor_valid && Dividend_valid;
    assign last_c   = (cnt == CNT_W'(1));

    // One restoring step. The shifted remainder keeps its top bit so that values
    // >= 2^(WIDTH-1) against a large divisor are not truncated; a negative
    // difference always shows up in bit WIDTH because |diff| < 2^WIDTH.
    assign shifted_c  = {rem, quo[WIDTH-1]};
    assign diff_c     = shifted_c - {1'b0, dvsr};
    assign borrow_c   = diff_c[WIDTH];
    assign rem_step_c = borrow_c ? shifted_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
    assign quo_step_c = {quo[WIDTH-2:0], ~borrow_c};

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept_c) state_nxt = CALC;
            CALC:    if (last_c)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rem        <= '0;
            quo        <= '0;
            dvsr       <= '0;
            cnt        <= '0;
            Dout_valid <= 1'b0;
            Dout_data  <= '0;
            Div_zero   <= 1'b0;
        end else begin
            // Pulse on the DONE -> IDLE edge so the next op can be accepted right away
            Dout_valid <= (state == DONE);
            unique case (state)
                IDLE: begin
                    if (accept_c) begin
                        rem      <= '0;
                        quo      <= Dividend_data;
                        dvsr     <= Divisor_data;
                        cnt      <= CNT_W'(WIDTH);
                        Div_zero <= (Divisor_data == '0);
                    end
                end
                CALC: begin
                    rem <= rem_step_c;
                    quo <= quo_step_c;
                    cnt <= cnt - CNT_W'(1);
                    if (last_c) begin
                        Dout_data <= {quo_step_c, rem_step_c};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Directed self-checking bench for iter_divider (WIDTH = 32).
module tb_iter_divider;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned LATENCY = WIDTH + 1;

    logic               Clk;
    logic               Rst_n;
    logic               Divisor_valid;
    logic [WIDTH-1:0]   Divisor_data;
    logic               Dividend_valid;
    logic [WIDTH-1:0]   Dividend_data;
    logic               Ready;
    logic               Dout_valid;
    logic [2*WIDTH-1:0] Dout_data;
    logic               Div_zero;

    int n_vec;
    int n_err;
    int dv_count;

    iter_divider #(.WIDTH(WIDTH)) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Divisor_valid  (Divisor_valid),
        .Divisor_data   (Divisor_data),
        .Dividend_valid (Dividend_valid),
        .Dividend_data  (Dividend_data),
        .Ready          (Ready),
        .Dout_valid     (Dout_valid),
        .Dout_data      (Dout_data),
        .Div_zero       (Div_zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Count every result pulse seen on a rising edge
    always @(posedge Clk) begin
        if (Dout_valid) dv_count <= dv_count + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; waits for Ready, presents a pair for one edge.
    task automatic start_op(input logic [WIDTH-1:0] dividend, input logic [WIDTH-1:0] divisor);
        int guard;
        guard = 0;
        while (!Ready && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        if (!Ready) chk("ready_wait", 64'(Ready), 64'(1));
        Dividend_data  = dividend;
        Divisor_data   = divisor;
        Dividend_valid = 1'b1;
        Divisor_valid  = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Dividend_valid = 1'b0;
        Divisor_valid  = 1'b0;
        chk("ready_low", 64'(Ready), 64'(0));
    endtask

    // Called at the negedge right after the accept edge; optionally fires a
    // second operand pair mid-calculation, which must be ignored.
    task automatic wait_result(input string tag, input bit inject,
                               input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r,
                               input logic exp_dz);
        int found;
        found = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (inject && n == 5) begin
                Dividend_data  = 32'd50;
                Divisor_data   = 32'd5;
                Dividend_valid = 1'b1;
                Divisor_valid  = 1'b1;
            end
            if (inject && n == 6) begin
                Dividend_valid = 1'b0;
                Divisor_valid  = 1'b0;
            end
            if (Dout_valid) begin
                found = n;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(found), 64'(LATENCY));
        chk({tag, "_data"},    Dout_data, {exp_q, exp_r});
        chk({tag, "_dz"},      64'(Div_zero), 64'(exp_dz));
        chk({tag, "_ready"},   64'(Ready), 64'(1));
        @(posedge Clk);
        @(negedge Clk);
        chk({tag, "_pulse"},   64'(Dout_valid), 64'(0));
    endtask

    task automatic do_div(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_q, input logic [WIDTH-1:0] exp_r,
                          input logic exp_dz);
        start_op(a, b);
        wait_result(tag, 1'b0, exp_q, exp_r, exp_dz);
    endtask

    initial begin
        int base;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;

        n_vec          = 0;
        n_err          = 0;
        dv_count       = 0;
        Rst_n          = 1'b0;
        Divisor_valid  = 1'b0;
        Dividend_valid = 1'b0;
        Divisor_data   = '0;
        Dividend_data  = '0;

        @(negedge Clk);
        @(negedge Clk);
        chk("rst_ready", 64'(Ready), 64'(1));
        chk("rst_dv",    64'(Dout_valid), 64'(0));
        chk("rst_data",  Dout_data, 64'(0));
        chk("rst_dz",    64'(Div_zero), 64'(0));
        Rst_n = 1'b1;
        @(negedge Clk);

        // Hand-computed directed vectors
        do_div("d100_7",    32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
        do_div("dmax_1",    32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFF,  32'h0,          1'b0);
        do_div("d8000_max", 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  1'b0);
        do_div("dfffe_max", 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'h0,          32'hFFFF_FFFE,  1'b0);
        do_div("d1234_0",   32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1);
        do_div("d7_100",    32'd7,          32'd100,        32'd0,          32'd7,          1'b0);
        do_div("dmax_max",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0);
        do_div("dmax_0",    32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1);
        do_div("d0_5",      32'd0,          32'd5,          32'd0,          32'd0,          1'b0);
        do_div("dbig",      32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32'h7FFF_FFFE,  1'b0);

        // Half a pair must never be accepted
        base = dv_count;
        Divisor_data  = 32'd3;
        Divisor_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("half_ready", 64'(Ready), 64'(1));
        end
        Divisor_valid = 1'b0;
        repeat (3) @(negedge Clk);
        chk("half_no_dv", 64'(dv_count - base), 64'(0));

        // Second pair during CALC is dropped
        base = dv_count;
        start_op(32'd9, 32'd2);
        wait_result("d9_2_inject", 1'b1, 32'd4, 32'd1, 1'b0);
        repeat (40) @(negedge Clk);
        chk("inject_one_dv", 64'(dv_count - base), 64'(1));
        chk("inject_ready",  64'(Ready), 64'(1));

        // Reset mid-CALC aborts without a result
        base = dv_count;
        start_op(32'd1000, 32'd3);
        repeat (10) begin
            @(posedge Clk);
            @(negedge Clk);
        end
        Rst_n = 1'b0;
        #1;
        chk("abort_ready", 64'(Ready), 64'(1));
        chk("abort_dv",    64'(Dout_valid), 64'(0));
        chk("abort_data",  Dout_data, 64'(0));
        chk("abort_dz",    64'(Div_zero), 64'(0));
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (40) @(negedge Clk);
        chk("abort_no_dv", 64'(dv_count - base), 64'(0));
        do_div("d1000_3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

        // A few pseudo-random pairs against / and %
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = '0;
                1: b = $urandom;
                2: b = $urandom >> $urandom_range(31, 1);
                default: b = 32'($urandom_range(1, 16));
            endcase
            if (i == 4) a = '0;
            if (i == 8) a = '1;
            q = (b == '0) ? '1 : a / b;
            r = (b == '0) ? a  : a % b;
            do_div("rand", a, b, q, r, (b == '0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
